// File: rtl/bmw_op_scheduler_if.sv
// Command-side bundle between the upstream producer/consumer, bmw_op_scheduler and the heap.
// The scheduler connects through the slave modport; the driving side uses master.
interface bmw_op_scheduler_if #(
    parameter int DW = 32,
    parameter int CW = 17
);
    // Handshake rule for both request streams: a transfer happens on a rising
    // edge where valid and ready are both high; valid never waits on ready, and
    // a producer holds its data stable while valid is high and ready is low.
    logic          i_push_valid;
    logic          o_push_ready;
    logic [DW-1:0] i_push_data;
    logic          i_pop_valid;
    logic          o_pop_ready;
    logic          o_push;
    logic [DW-1:0] o_push_data;
    logic          o_pop;
    logic [DW-1:0] i_heap_pop_data;
    logic          o_deq_valid;
    logic [DW-1:0] o_deq_data;
    logic [CW-1:0] o_count;

    modport slave (
        input  i_push_valid, i_push_data, i_pop_valid, i_heap_pop_data,
        output o_push_ready, o_pop_ready, o_push, o_push_data, o_pop,
               o_deq_valid, o_deq_data, o_count
    );

    modport master (
        output i_push_valid, i_push_data, i_pop_valid, i_heap_pop_data,
        input  o_push_ready, o_pop_ready, o_push, o_push_data, o_pop,
               o_deq_valid, o_deq_data, o_count
    );
endinterface

// File: rtl/bmw_op_scheduler.sv
// Push/pop issue scheduler in front of the BMW heap: push FIFO, occupancy count, fair arbiter, pop realignment.
// Optional BMW_SCHED_STATS_EN adds free-running 32-bit push/pop/stall counters.
module bmw_op_scheduler #(
    parameter int PTW        = 16,
    parameter int MTW        = 16,
    parameter int CAPACITY   = 87380,
    parameter int FIFO_DEPTH = 4,
    parameter int OP_GAP     = 1,
    parameter int POP_LAT    = 2
) (
    input  logic i_clk,
    input  logic i_arst,
    bmw_op_scheduler_if.slave bus
`ifdef BMW_SCHED_STATS_EN
    ,
    output logic [31:0] o_stat_push,
    output logic [31:0] o_stat_pop,
    output logic [31:0] o_stat_stall
`endif
);
    localparam int DW = MTW + PTW;
    localparam int CW = $clog2(CAPACITY + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (OP_GAP > 1) ? $clog2(OP_GAP) : 1;

    localparam logic [CW-1:0] CAP      = CW'(CAPACITY);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(OP_GAP - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    logic [DW-1:0]      fifo_mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_wr;
    logic [CW-1:0]      count;
    logic [GW-1:0]      gap;
    logic               last_grant_push;
    logic               push_elig;
    logic               pop_elig;
    logic               grant_push;
    logic               grant_pop;
    logic [POP_LAT-1:0] pop_sr;

    // Extra pointer bit distinguishes full from empty when the low bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_wr    = bus.i_push_valid && !fifo_full;

    assign bus.o_push_ready = !fifo_full;
    assign bus.o_pop_ready  = grant_pop;
    assign bus.o_count      = count;

    assign push_elig = !fifo_empty && (count < CAP) && (gap == '0);
    assign pop_elig  = bus.i_pop_valid && (count != '0) && (gap == '0);

    // On a tie the side that did not win last time gets the slot.
    assign grant_push = push_elig && (!pop_elig || !last_grant_push);
    assign grant_pop  = pop_elig  && (!push_elig || last_grant_push);

    always_ff @(posedge i_clk) begin
        if (fifo_wr) fifo_mem[wr_ptr[AW-1:0]] <= bus.i_push_data;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            gap             <= '0;
            last_grant_push <= 1'b0;
            pop_sr          <= '0;
            bus.o_push      <= 1'b0;
            bus.o_pop       <= 1'b0;
            bus.o_push_data <= '0;
            bus.o_deq_valid <= 1'b0;
            bus.o_deq_data  <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + PTR_ONE;

            bus.o_push <= grant_push;
            bus.o_pop  <= grant_pop;

            if (grant_push) begin
                rd_ptr          <= rd_ptr + PTR_ONE;
                bus.o_push_data <= fifo_mem[rd_ptr[AW-1:0]];
                count           <= count + CNT_ONE;
            end else if (grant_pop) begin
                count <= count - CNT_ONE;
            end

            if (grant_push || grant_pop) begin
                gap             <= GAP_LOAD;
                last_grant_push <= grant_push;
            end else if (gap != '0) begin
                gap <= gap - GAP_ONE;
            end

            // Last tap lines up with the cycle the heap presents its pop result.
            pop_sr[0] <= bus.o_pop;
            for (int i = 1; i < POP_LAT; i++) pop_sr[i] <= pop_sr[i-1];

            bus.o_deq_valid <= pop_sr[POP_LAT-1];
            if (pop_sr[POP_LAT-1]) bus.o_deq_data <= bus.i_heap_pop_data;
        end
    end

`ifdef BMW_SCHED_STATS_EN
    logic stall;

    // A request is waiting but no slot was issued: heap full, heap empty or gap.
    assign stall = (!fifo_empty || bus.i_pop_valid) && !grant_push && !grant_pop;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_stat_push  <= '0;
            o_stat_pop   <= '0;
            o_stat_stall <= '0;
        end else begin
            if (grant_push) o_stat_push  <= o_stat_push + 32'd1;
            if (grant_pop)  o_stat_pop   <= o_stat_pop + 32'd1;
            if (stall)      o_stat_stall <= o_stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/bmw_op_scheduler.md
# bmw_op_scheduler

Upstream command stage for `bmw_sram_top`.
- Accepts a valid/ready push stream and a valid/ready pop-request stream.
- Buffers pushes in a small FIFO and tracks heap occupancy.
- Issues at most one push or pop to the heap per issue slot, never pushing when full and never popping when empty.
- Realigns the heap's delayed pop data into a one-cycle dequeue strobe.

## Interface
Parameters:
- `PTW`, 16: priority bits.
- `MTW`, 16: metadata bits; entry width `DW = MTW+PTW`.
- `CAPACITY`, 87380: heap element capacity (NB_ELEMENTS for ORDER 4, LEVEL 8); counter width `CW = $clog2(CAPACITY+1)`.
- `FIFO_DEPTH`, 4: push buffer depth, power of two, ≥2.
- `OP_GAP`, 1: minimum cycles between issued ops (1 = every cycle).
- `POP_LAT`, 2: cycles from heap pop strobe to valid `i_heap_pop_data`, ≥1.

Ports:
- `i_clk`, input, 1: clock.
- `i_arst`, input, 1: reset, asynchronous and active-high.
- `i_push_valid`, input, 1: push entry offered.
- `o_push_ready`, output, 1: FIFO can accept.
- `i_push_data`, input, DW: entry.
- `i_pop_valid`, input, 1: pop requested.
- `o_pop_ready`, output, 1: pop granted this cycle.
- `o_push`, output, 1: heap push strobe.
- `o_push_data`, output, DW: heap push data.
- `o_pop`, output, 1: heap pop strobe.
- `i_heap_pop_data`, input, DW: heap pop result.
- `o_deq_valid`, output, 1: dequeued entry valid (no backpressure).
- `o_deq_data`, output, DW: dequeued entry.
- `o_count`, output, CW: committed heap occupancy.

## Operation
- Push FIFO: write on `i_push_valid && o_push_ready`. `o_push_ready = !fifo_full` is registered-state only, with no same-cycle dependence on a read.
- Eligibility:
  - Push is eligible when the FIFO is non-empty, `count < CAPACITY`, and `gap == 0`.
  - Pop is eligible when `i_pop_valid`, `count > 0`, and `gap == 0`.
- Arbiter: if exactly one is eligible, grant it. If both are eligible, grant the type opposite to `last_grant`. Reset value of `last_grant` is pop, so push wins the first tie.
- Grant push: pop the FIFO head into the `o_push_data` register, `o_push<=1`, `count+1`.
- Grant pop: `o_pop_ready=1` combinationally in the grant cycle, `o_pop<=1`, `count-1`.
- Never both strobes in one cycle.
- Gap counter: on any grant, load `OP_GAP-1`; otherwise decrement while nonzero.
- Count is updated at grant. A push granted at `count==CAPACITY-1` makes it full, and the next push waits for a pop.
- Pop tracking: a POP_LAT-deep valid shift register is fed by `o_pop`.

## Timing
- Reset: `o_push`, `o_pop`, `o_deq_valid` = 0; `o_push_data`, `o_deq_data` = 0; `o_count` = 0; FIFO empty; `o_push_ready` = 1; `gap` = 0; shift register cleared.
- Push latency: an entry written in an empty FIFO at cycle T is granted at T+1 and `o_push` is high at T+2, given no contention.
- Pop: granted at T, `o_pop` high at T+1. `i_heap_pop_data` is sampled at T+1+POP_LAT. `o_deq_valid`/`o_deq_data` are high for exactly one cycle at T+2+POP_LAT.
- With `OP_GAP=1` and both sides saturated, grants alternate push/pop every cycle.
- A full FIFO written and read in the same cycle: write refused (ready low), read proceeds.
- An asynchronous reset mid-flight discards in-flight pops: no `o_deq_valid` after reset.

## Configuration
- `BMW_SCHED_STATS_EN`:
  - Defined: adds 32-bit outputs `o_stat_push`, `o_stat_pop` (issued-op counts) and `o_stat_stall`. `o_stat_stall` counts cycles in which a request was pending but blocked by full, empty, or gap. All three wrap at 2^32 and reset to 0.
  - Undefined: the ports and logic are absent and behaviour is otherwise identical.

## Test plan
- Reset, then 3 pushes (data 0x0001_0005, 0x0002_0003, 0x0003_0009), no pops: `o_push` at cycles 2, 3, 4 after the first accept, data in order; `o_count`=3.
- `o_count`=0 with `i_pop_valid` held 5 cycles: `o_pop_ready` stays 0, no `o_pop`, no `o_deq_valid`.
- Both sides saturated, `OP_GAP=1`: strobes alternate push, pop, push…. With `i_heap_pop_data` driven to 0xABCD, `o_deq_valid` rises POP_LAT+1 cycles after each `o_pop` with `o_deq_data`=0xABCD.
- `CAPACITY`=4: push 6 entries; 4 issued, `o_count`=4, and the FIFO holds 2. One pop issues, then exactly one further push; `o_count` returns to 4.
- `OP_GAP=3`, continuous pushes: `o_push` pulses are spaced exactly 3 cycles apart.
- Assert `i_arst` one cycle after `o_pop`: all outputs 0 immediately, no `o_deq_valid` in the following POP_LAT+2 cycles, `o_push_ready`=1.
